mini_risc_ctrl_fsm: RTL

- Multi-cycle control unit that sequences the KGP mini-RISC data_path.
- Takes opcode_out/func_out from data_path and walks each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK.
- Drives every data_path control input, plus fetch enables (pc_en, ir_en).
- Replaces the hand-driven control waveforms used in current datapath benches.

---
 rtl/mini_risc_pkg.sv | 83 ++++++++
 rtl/mini_risc_ctrl_fsm_if.sv | 36 +++
 rtl/mini_risc_decoder.sv | 53 +++++
 rtl/mini_risc_ctrl_fsm.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/mini_risc_pkg.sv
// Shared types and encodings for the mini-RISC multi-cycle controller.
package mini_risc_pkg;

   // Controller states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6,
      ST_TRAP   = 3'd7
   } state_t;

   // Instruction classes produced by the decoder
   typedef enum logic [2:0] {
      CLS_ALU  = 3'd0,
      CLS_LW   = 3'd1,
      CLS_SW   = 3'd2,
      CLS_BR   = 3'd3,
      CLS_HALT = 3'd4,
      CLS_ILL  = 3'd5
   } cls_t;

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ITYPE = 6'h01;
   localparam logic [5:0] OP_LW    = 6'h02;
   localparam logic [5:0] OP_SW    = 6'h03;
   localparam logic [5:0] OP_BR    = 6'h04;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   // ALU operations (RTYPE/ITYPE pass func[3:0] straight through)
   localparam logic [3:0] ALU_ADD  = 4'h0;
   localparam logic [3:0] ALU_COMP = 4'h1;
   localparam logic [3:0] ALU_XOR  = 4'h3;

   // Legal func ranges
   localparam logic [5:0] RTYPE_FUNC_MAX = 6'h09;
   localparam logic [4:0] BR_FUNC_MAX    = 5'h0C;

   // Register write enable encodings
   localparam logic [1:0] RW_NONE = 2'b00;
   localparam logic [1:0] RW_ALU  = 2'b01;
   localparam logic [1:0] RW_LOAD = 2'b10;

   // Register write-back mux encodings
   localparam logic [1:0] RWM_NONE = 2'b00;
   localparam logic [1:0] RWM_ALU  = 2'b10;
   localparam logic [1:0] RWM_MEM  = 2'b01;

   // Per-instruction control bundle from the decoder
   typedef struct packed {
      logic [3:0] alu_op;
      logic       alu_mux;
      logic       imm_mux;
      logic [4:0] br_op;
   } ctrl_t;

   // Registered controller outputs
   typedef struct packed {
      logic       pc_en;
      logic       ir_en;
      logic [1:0] reg_write;
      logic       imm_mux_ctrl;
      logic       alu_mux_ctrl;
      logic [3:0] alu_op;
      logic       dmem_enable;
      logic       dmem_write_enable;
      logic [1:0] reg_write_mux_ctrl;
      logic [4:0] br_op;
      logic       busy;
      logic       halted;
      logic       illegal;
   } outs_t;

   // States in which the controller is actively sequencing an instruction
   function automatic logic is_busy_state(state_t s);
      return !(s == ST_IDLE || s == ST_HALT || s == ST_TRAP);
   endfunction

endpackage

// File: rtl/mini_risc_ctrl_fsm_if.sv
// Controller <-> data_path bundle. master = controller, slave = data_path side.
interface mini_risc_ctrl_fsm_if #(
   parameter int OPCODE_W = 6,
   parameter int FUNC_W   = 6
);
   logic                start;
   logic [OPCODE_W-1:0] opcode;
   logic [FUNC_W-1:0]   func;
   logic                pc_en;
   logic                ir_en;
   logic [1:0]          reg_write;
   logic                imm_mux_ctrl;
   logic                alu_mux_ctrl;
   logic [3:0]          alu_op;
   logic                dmem_enable;
   logic                dmem_write_enable;
   logic [1:0]          reg_write_mux_ctrl;
   logic [4:0]          br_op;
   logic                busy;
   logic                halted;
   logic                illegal;

   modport master (
      input  start, opcode, func,
      output pc_en, ir_en, reg_write, imm_mux_ctrl, alu_mux_ctrl, alu_op,
             dmem_enable, dmem_write_enable, reg_write_mux_ctrl, br_op,
             busy, halted, illegal
   );

   modport slave (
      output start, opcode, func,
      input  pc_en, ir_en, reg_write, imm_mux_ctrl, alu_mux_ctrl, alu_op,
             dmem_enable, dmem_write_enable, reg_write_mux_ctrl, br_op,
             busy, halted, illegal
   );
endinterface

// File: rtl/mini_risc_decoder.sv
// Combinational opcode/func classifier; anything not recognised is CLS_ILL.
module mini_risc_decoder
   import mini_risc_pkg::*;
#(
   parameter int OPCODE_W = 6,
   parameter int FUNC_W   = 6
) (
   input  logic [OPCODE_W-1:0] opcode_i,
   input  logic [FUNC_W-1:0]   func_i,
   output cls_t                cls_o,
   output ctrl_t               ctrl_o
);

   // Classify and build the control bundle; default is an illegal, all-zero bundle
   always_comb begin
      cls_o  = CLS_ILL;
      ctrl_o = '0;
      case (opcode_i)
         OPCODE_W'(OP_RTYPE): begin
            if (func_i <= FUNC_W'(RTYPE_FUNC_MAX)) begin
               cls_o         = CLS_ALU;
               ctrl_o.alu_op = func_i[3:0];
            end
         end
         OPCODE_W'(OP_ITYPE): begin
            cls_o          = CLS_ALU;
            ctrl_o.alu_op  = func_i[3:0];
            ctrl_o.alu_mux = 1'b1;
         end
         OPCODE_W'(OP_LW): begin
            cls_o          = CLS_LW;
            ctrl_o.alu_op  = ALU_ADD;
            ctrl_o.alu_mux = 1'b1;
            ctrl_o.imm_mux = 1'b1;
         end
         OPCODE_W'(OP_SW): begin
            cls_o          = CLS_SW;
            ctrl_o.alu_op  = ALU_ADD;
            ctrl_o.alu_mux = 1'b1;
            ctrl_o.imm_mux = 1'b1;
         end
         OPCODE_W'(OP_BR): begin
            if (func_i[4:0] != 5'd0 && func_i[4:0] <= BR_FUNC_MAX) begin
               cls_o        = CLS_BR;
               ctrl_o.br_op = func_i[4:0];
            end
         end
         OPCODE_W'(OP_HALT): cls_o = CLS_HALT;
         default:            cls_o = CLS_ILL;
      endcase
   end

endmodule

// File: rtl/mini_risc_ctrl_fsm.sv
// Multi-cycle mini-RISC controller: FETCH/DECODE/EXEC/MEM/WB with Moore
// registered outputs, computed from the next state so each strobe lines up
// exactly with the state it belongs to.
module mini_risc_ctrl_fsm
   import mini_risc_pkg::*;
#(
   parameter int OPCODE_W = 6,
   parameter int FUNC_W   = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   mini_risc_ctrl_fsm_if.master  bus
);

   state_t state_q, state_d;
   cls_t   cls_q, dec_cls, cls_nx;
   ctrl_t  ctrl_q, dec_ctrl, ctrl_nx;
   outs_t  out_q, out_d;

   mini_risc_decoder #(
      .OPCODE_W (OPCODE_W),
      .FUNC_W   (FUNC_W)
   ) u_dec (
      .opcode_i (bus.opcode),
      .func_i   (bus.func),
      .cls_o    (dec_cls),
      .ctrl_o   (dec_ctrl)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Capture the decode result once, in DECODE; later opcode/func changes are ignored
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cls_q  <= CLS_ILL;
         ctrl_q <= '0;
      end else if (state_q == ST_DECODE) begin
         cls_q  <= dec_cls;
         ctrl_q <= dec_ctrl;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (bus.start) state_d = ST_FETCH;
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: begin
            case (dec_cls)
               CLS_ILL:  state_d = ST_TRAP;
               CLS_HALT: state_d = ST_HALT;
               default:  state_d = ST_EXEC;
            endcase
         end
         ST_EXEC: begin
            case (cls_q)
               CLS_LW, CLS_SW: state_d = ST_MEM;
               CLS_BR:         state_d = ST_FETCH;
               CLS_ALU:        state_d = ST_WB;
               default:        state_d = ST_TRAP;
            endcase
         end
         ST_MEM:    state_d = (cls_q == CLS_LW) ? ST_WB : ST_FETCH;
         ST_WB:     state_d = ST_FETCH;
         ST_HALT:   state_d = ST_HALT;
         ST_TRAP:   state_d = ST_TRAP;
         default:   state_d = ST_TRAP;
      endcase
   end

   // Class/bundle of the instruction the next state belongs to: on the
   // DECODE->EXEC edge the capture register is not loaded yet, so bypass it.
   assign cls_nx  = (state_q == ST_DECODE) ? dec_cls  : cls_q;
   assign ctrl_nx = (state_q == ST_DECODE) ? dec_ctrl : ctrl_q;

   // Output decode from the next state; ALU controls stay up from EXEC through MEM/WB
   always_comb begin
      out_d        = '0;
      out_d.busy   = is_busy_state(state_d);
      out_d.halted = (state_d == ST_HALT);
      out_d.illegal = (state_d == ST_TRAP);
      if (state_d == ST_EXEC || state_d == ST_MEM || state_d == ST_WB) begin
         out_d.alu_op       = ctrl_nx.alu_op;
         out_d.alu_mux_ctrl = ctrl_nx.alu_mux;
         out_d.imm_mux_ctrl = ctrl_nx.imm_mux;
      end
      case (state_d)
         ST_FETCH: out_d.ir_en = 1'b1;
         ST_EXEC: begin
            if (cls_nx == CLS_BR) begin
               out_d.br_op = ctrl_nx.br_op;
               out_d.pc_en = 1'b1;
            end
         end
         ST_MEM: begin
            out_d.dmem_enable = 1'b1;
            if (cls_nx == CLS_SW) begin
               out_d.dmem_write_enable = 1'b1;
               out_d.pc_en             = 1'b1;
            end
         end
         ST_WB: begin
            out_d.pc_en = 1'b1;
            if (cls_nx == CLS_LW) begin
               out_d.reg_write          = RW_LOAD;
               out_d.reg_write_mux_ctrl = RWM_MEM;
            end else begin
               out_d.reg_write          = RW_ALU;
               out_d.reg_write_mux_ctrl = RWM_ALU;
            end
         end
         default: ;
      endcase
   end

   // Output register; async reset clears every control immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) out_q <= '0;
      else     out_q <= out_d;
   end

   assign bus.pc_en              = out_q.pc_en;
   assign bus.ir_en              = out_q.ir_en;
   assign bus.reg_write          = out_q.reg_write;
   assign bus.imm_mux_ctrl       = out_q.imm_mux_ctrl;
   assign bus.alu_mux_ctrl       = out_q.alu_mux_ctrl;
   assign bus.alu_op             = out_q.alu_op;
   assign bus.dmem_enable        = out_q.dmem_enable;
   assign bus.dmem_write_enable  = out_q.dmem_write_enable;
   assign bus.reg_write_mux_ctrl = out_q.reg_write_mux_ctrl;
   assign bus.br_op              = out_q.br_op;
   assign bus.busy               = out_q.busy;
   assign bus.halted             = out_q.halted;
   assign bus.illegal            = out_q.illegal;

endmodule
